// File: rtl/microcontrolador_condicionador_entrada.sv
// microcontrolador_condicionador_entrada: synchronise and debounce board pins ahead of the pinos_entrada PIO
//   clk           system clock
//   reset         synchronous active-high reset
//   pins_raw      asynchronous board pins
//   pins_clean    debounced level, feeds the PIO in_port
//   rise_pulse    one-cycle pulse per bit when pins_clean goes 0->1
//   fall_pulse    one-cycle pulse per bit when pins_clean goes 1->0
//   edge_clear    clear mask for edge_capture       (MICROCONTROLADOR_EDGE_CAPTURE_EN)
//   edge_capture  sticky rising-edge flags          (MICROCONTROLADOR_EDGE_CAPTURE_EN)
//   irq           registered OR of edge_capture     (MICROCONTROLADOR_EDGE_CAPTURE_EN)
module microcontrolador_condicionador_entrada #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins_raw,
  output logic [WIDTH-1:0] pins_clean,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
`ifdef MICROCONTROLADOR_EDGE_CAPTURE_EN
  ,
  input  logic [WIDTH-1:0] edge_clear,
  output logic [WIDTH-1:0] edge_capture,
  output logic             irq
`endif
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] s, done, clean_q, clean_d, rise_q, rise_d, fall_q, fall_d;
  assign s = sync_q[SYNC_STAGES-1];
  // done: the mismatch has persisted for the full debounce window this cycle
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign done[i]  = (s[i] != clean_q[i]) && (cnt_q[i] == LAST);
    assign cnt_d[i] = (s[i] != clean_q[i] && !done[i]) ? cnt_q[i] + 1'b1 : '0;
  end
  assign clean_d = (clean_q & ~done) | (s & done);
  assign rise_d  = done & s;
  assign fall_d  = done & ~s;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '{default: '0};
      cnt_q   <= '{default: '0};
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync_q[0] <= pins_raw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end
  assign pins_clean = clean_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
`ifdef MICROCONTROLADOR_EDGE_CAPTURE_EN
  logic [WIDTH-1:0] cap_q, cap_d;
  logic             irq_q, irq_d;
  // a new rising edge outranks a clear arriving in the same cycle
  assign cap_d = (cap_q & ~edge_clear) | rise_q;
  assign irq_d = |cap_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cap_q <= cap_d;
      irq_q <= irq_d;
    end
  end
  assign edge_capture = cap_q;
  assign irq          = irq_q;
`endif
endmodule

// File: tb/tb_microcontrolador_condicionador_entrada.sv
// tb_microcontrolador_condicionador_entrada: scoreboard bench for the input conditioner
module tb_microcontrolador_condicionador_entrada;
  typedef struct {
    int         due;
    logic [7:0] clean;
    logic [7:0] rise;
    logic [7:0] fall;
  } ev_t;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pins_raw = 8'hFF;
  logic [7:0] pins_clean, rise_pulse, fall_pulse;
`ifdef MICROCONTROLADOR_EDGE_CAPTURE_EN
  logic [7:0] edge_clear = 8'h00;
  logic [7:0] edge_capture;
  logic       irq;
`endif
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  ev_t  q[$];
  microcontrolador_condicionador_entrada #(
    .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pins_raw(pins_raw),
    .pins_clean(pins_clean),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
`ifdef MICROCONTROLADOR_EDGE_CAPTURE_EN
    ,
    .edge_clear(edge_clear),
    .edge_capture(edge_capture),
    .irq(irq)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // called right after edge cyc, once the new pin level has been driven
  task automatic expect_ev(input logic [7:0] clean, input logic [7:0] rise, input logic [7:0] fall);
    ev_t e;
    e.due = cyc + 6;
    e.clean = clean;
    e.rise = rise;
    e.fall = fall;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (rise_pulse !== 8'h00 || fall_pulse !== 8'h00) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {8'h0, pins_clean, rise_pulse, fall_pulse}, 32'h0);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.due);
        chk("pulse_clean", {24'h0, pins_clean}, {24'h0, e.clean});
        chk("pulse_rise", {24'h0, rise_pulse}, {24'h0, e.rise});
        chk("pulse_fall", {24'h0, fall_pulse}, {24'h0, e.fall});
      end
    end
  end
  initial begin
    tick(3);
    chk("reset_outputs", {8'h0, pins_clean, rise_pulse, fall_pulse}, 32'h0);
    reset = 1'b0;
    expect_ev(8'hFF, 8'hFF, 8'h00);
    tick(5);
    chk("release_before", {24'h0, pins_clean}, 32'h00);
    tick(1);
    chk("release_clean", {24'h0, pins_clean}, 32'hFF);
    tick(1);
    chk("release_rise_off", {24'h0, rise_pulse}, 32'h00);
    pins_raw = 8'h5A;
    expect_ev(8'h5A, 8'h00, 8'hA5);
    tick(5);
    chk("fall_before", {24'h0, pins_clean}, 32'hFF);
    tick(1);
    chk("fall_clean", {24'h0, pins_clean}, 32'h5A);
    tick(1);
    chk("fall_pulse_off", {24'h0, fall_pulse}, 32'h00);
    pins_raw = 8'h5B;
    tick(3);
    pins_raw = 8'h5A;
    tick(8);
    chk("glitch_rejected", {24'h0, pins_clean}, 32'h5A);
    pins_raw = 8'h00;
    expect_ev(8'h00, 8'h00, 8'h5A);
    tick(8);
    chk("all_low", {24'h0, pins_clean}, 32'h00);
    pins_raw = 8'h08;
    tick(3);
    reset = 1'b1;
    tick(1);
    chk("midcount_reset", {8'h0, pins_clean, rise_pulse, fall_pulse}, 32'h0);
    reset = 1'b0;
    expect_ev(8'h08, 8'h08, 8'h00);
    tick(5);
    chk("post_reset_before", {24'h0, pins_clean}, 32'h00);
    tick(1);
    chk("post_reset_rise", {24'h0, pins_clean}, 32'h08);
    tick(2);
    expect_ev(8'h4A, 8'h42, 8'h00);
    for (int i = 0; i < 8; i++) begin
      pins_raw = (i % 2 == 1) ? 8'h5A : 8'h4A;
      tick(1);
    end
    pins_raw = 8'h4A;
    tick(4);
    chk("bounce_bit4_low", {24'h0, pins_clean}, 32'h4A);
`ifdef MICROCONTROLADOR_EDGE_CAPTURE_EN
    edge_clear = 8'hFF;
    tick(1);
    edge_clear = 8'h00;
    tick(2);
    chk("cap_cleared", {23'h0, irq, edge_capture}, 32'h0);
    pins_raw = 8'h4E;
    expect_ev(8'h4E, 8'h04, 8'h00);
    tick(6);
    edge_clear = 8'h04;
    tick(1);
    edge_clear = 8'h00;
    chk("cap_set_wins", {24'h0, edge_capture}, 32'h04);
    chk("irq_lag", {31'h0, irq}, 32'h0);
    tick(1);
    chk("irq_set", {31'h0, irq}, 32'h1);
    edge_clear = 8'h04;
    tick(1);
    edge_clear = 8'h00;
    chk("cap_clear", {24'h0, edge_capture}, 32'h00);
    chk("irq_hold", {31'h0, irq}, 32'h1);
    tick(1);
    chk("irq_clear", {31'h0, irq}, 32'h0);
`endif
    tick(10);
    chk("queue_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
